uart_cfg_core: RTL and testbench

//  Next-generation UART core: TX and RX engines with 16x oversampling, runtime baud divisor,

---
 rtl/uart_cfg_core.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_cfg_core.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_core.sv
// uart_cfg_core: runtime-configurable UART with 16x oversampling, TX/RX FIFOs,
// RTS/CTS flow control and internal loopback.
//
// Ports
//   SysClk, Rst             clock, asynchronous active-low reset
//   Baud_Div                SysClk cycles per oversample tick (0 behaves as 1)
//   Parity_Mode, Two_Stop   frame format, latched by each engine at frame start
//   Loopback                RX fed from the internal TX line, Tx pin held high
//   Tx_Data/Valid/Ready     TX FIFO write handshake
//   Rx_Data/Valid/Ready     RX FIFO first-word-fall-through read handshake
//   Rx, Tx                  serial pins
//   CTS, RTS                flow control (CTS synchronised, RTS registered)
//   Tx_Busy, Tx/Rx_Count    status
//   Err_Clr, Rx_*_Err/Overflow  sticky receive errors and their clear
module uart_cfg_core #(
    parameter  int DATA_BITS  = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int RTS_MARGIN = 2,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic [15:0]          Baud_Div,
    input  logic [1:0]           Parity_Mode,
    input  logic                 Two_Stop,
    input  logic                 Loopback,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Tx_Valid,
    output logic                 Tx_Ready,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    input  logic                 Rx_Ready,
    input  logic                 Rx,
    output logic                 Tx,
    input  logic                 CTS,
    output logic                 RTS,
    output logic                 Tx_Busy,
    output logic [CW-1:0]        Tx_Count,
    output logic [CW-1:0]        Rx_Count,
    input  logic                 Err_Clr,
    output logic                 Rx_Parity_Err,
    output logic                 Rx_Frame_Err,
    output logic                 Rx_Overflow
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RTS_LIM  = CW'(FIFO_DEPTH - RTS_MARGIN);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- oversample tick ----------------
    logic [15:0] r_tick_cnt;
    logic        w_tick;
    assign w_tick = (r_tick_cnt == 16'd0);

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst)        r_tick_cnt <= 16'd0;
        else if (w_tick) r_tick_cnt <= (Baud_Div == 16'd0) ? 16'd0 : Baud_Div - 16'd1;
        else             r_tick_cnt <= r_tick_cnt - 16'd1;
    end

    // ---------------- synchronisers ----------------
    logic w_tx_line, w_rx_line_in;
    logic r_cts_s1, r_cts_s2, r_rx_s1, r_rx_s2, r_rx_s3;
    assign w_rx_line_in = Loopback ? w_tx_line : Rx;

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_cts_s1 <= 1'b0; r_cts_s2 <= 1'b0;
            r_rx_s1  <= 1'b1; r_rx_s2  <= 1'b1; r_rx_s3 <= 1'b1;
        end else begin
            r_cts_s1 <= CTS;          r_cts_s2 <= r_cts_s1;
            r_rx_s1  <= w_rx_line_in; r_rx_s2  <= r_rx_s1;  r_rx_s3 <= r_rx_s2;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_tx_wp, r_tx_rp;
    logic [CW-1:0]        r_tx_cnt, w_tx_cnt_nxt;
    logic                 r_tx_rdy, w_tx_wr, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;

    assign w_tx_wr      = Tx_Valid && r_tx_rdy;
    assign w_tx_head    = r_tx_mem[r_tx_rp];
    assign w_tx_cnt_nxt = r_tx_cnt + CW'(w_tx_wr) - CW'(w_tx_pop);

    always_ff @(posedge SysClk) begin
        if (w_tx_wr) r_tx_mem[r_tx_wp] <= Tx_Data;
    end

    // Ready is registered from the next count, so a pop at full only frees
    // a slot for writers on the following cycle.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0; r_tx_rdy <= 1'b1;
        end else begin
            if (w_tx_wr)  r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop) r_tx_rp <= r_tx_rp + AW'(1);
            r_tx_cnt <= w_tx_cnt_nxt;
            r_tx_rdy <= (w_tx_cnt_nxt != FULL);
        end
    end

    // ---------------- TX engine ----------------
    state_t               r_tx_st, w_tx_nxt;
    logic [3:0]           r_tx_tcnt, r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_sh;
    logic                 r_tx_par_en, r_tx_par_bit, r_tx_two, w_tx_adv;
    assign w_tx_adv = w_tick && (r_tx_tcnt == 4'd15);

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) r_tx_st <= S_IDLE;
        else      r_tx_st <= w_tx_nxt;
    end

    // The line is decoded from state so a reset returns Tx high immediately.
    always_comb begin
        w_tx_nxt  = r_tx_st;
        w_tx_pop  = 1'b0;
        w_tx_line = 1'b1;
        case (r_tx_st)
            S_IDLE:   if (w_tick && r_tx_cnt != '0 && r_cts_s2) begin
                          w_tx_nxt = S_START;
                          w_tx_pop = 1'b1;
                      end
            S_START:  begin
                          w_tx_line = 1'b0;
                          if (w_tx_adv) w_tx_nxt = S_DATA;
                      end
            S_DATA:   begin
                          w_tx_line = r_tx_sh[0];
                          if (w_tx_adv && r_tx_bit == LAST_BIT)
                              w_tx_nxt = r_tx_par_en ? S_PARITY : S_STOP;
                      end
            S_PARITY: begin
                          w_tx_line = r_tx_par_bit;
                          if (w_tx_adv) w_tx_nxt = S_STOP;
                      end
            S_STOP:   if (w_tx_adv && (!r_tx_two || r_tx_bit == 4'd1)) w_tx_nxt = S_IDLE;
            default:  w_tx_nxt = S_IDLE;
        endcase
    end

    // r_tx_bit indexes data bits, is left at 0 on leaving DATA, then counts stop bits.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_tx_tcnt <= 4'd0; r_tx_bit <= 4'd0; r_tx_sh <= '0;
            r_tx_par_en <= 1'b0; r_tx_par_bit <= 1'b0; r_tx_two <= 1'b0;
        end else if (w_tx_pop) begin
            r_tx_sh      <= w_tx_head;
            r_tx_tcnt    <= 4'd0;
            r_tx_bit     <= 4'd0;
            r_tx_par_en  <= (Parity_Mode == 2'b01) || (Parity_Mode == 2'b10);
            r_tx_par_bit <= (^w_tx_head) ^ (Parity_Mode == 2'b10);
            r_tx_two     <= Two_Stop;
        end else if (r_tx_st != S_IDLE && w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 4'd1;
            if (w_tx_adv) begin
                if (r_tx_st == S_DATA) begin
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx_bit <= (r_tx_bit == LAST_BIT) ? 4'd0 : r_tx_bit + 4'd1;
                end else if (r_tx_st == S_STOP) begin
                    r_tx_bit <= r_tx_bit + 4'd1;
                end
            end
        end
    end

    assign Tx       = Loopback ? 1'b1 : w_tx_line;
    assign Tx_Busy  = (r_tx_st != S_IDLE) || (r_tx_cnt != '0);
    assign Tx_Ready = r_tx_rdy;
    assign Tx_Count = r_tx_cnt;

    // ---------------- RX engine ----------------
    state_t               r_rx_st, w_rx_nxt;
    logic [3:0]           r_rx_tcnt, r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_sh;
    logic                 r_rx_par_en, r_rx_par_odd, r_rx_pbit;
    logic                 w_rx_smp, w_rx_adv, w_rx_start, w_rx_push;
    assign w_rx_smp = w_tick && (r_rx_tcnt == 4'd7);
    assign w_rx_adv = w_tick && (r_rx_tcnt == 4'd15);

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) r_rx_st <= S_IDLE;
        else      r_rx_st <= w_rx_nxt;
    end

    // Returns to IDLE right at the stop sample so the next start edge is caught.
    always_comb begin
        w_rx_nxt   = r_rx_st;
        w_rx_start = 1'b0;
        w_rx_push  = 1'b0;
        case (r_rx_st)
            S_IDLE:   if (r_rx_s3 && !r_rx_s2) begin
                          w_rx_nxt   = S_START;
                          w_rx_start = 1'b1;
                      end
            S_START:  if (w_rx_smp && r_rx_s2) w_rx_nxt = S_IDLE;   // glitch
                      else if (w_rx_adv)       w_rx_nxt = S_DATA;
            S_DATA:   if (w_rx_adv && r_rx_bit == LAST_BIT)
                          w_rx_nxt = r_rx_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_adv) w_rx_nxt = S_STOP;
            S_STOP:   if (w_rx_smp) begin
                          w_rx_nxt  = S_IDLE;
                          w_rx_push = 1'b1;
                      end
            default:  w_rx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_rx_tcnt <= 4'd0; r_rx_bit <= 4'd0; r_rx_sh <= '0;
            r_rx_par_en <= 1'b0; r_rx_par_odd <= 1'b0; r_rx_pbit <= 1'b0;
        end else if (w_rx_start) begin
            r_rx_tcnt    <= 4'd0;
            r_rx_bit     <= 4'd0;
            r_rx_par_en  <= (Parity_Mode == 2'b01) || (Parity_Mode == 2'b10);
            r_rx_par_odd <= (Parity_Mode == 2'b10);
        end else if (r_rx_st != S_IDLE && w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
            if (r_rx_st == S_DATA && w_rx_smp)   r_rx_sh   <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
            if (r_rx_st == S_PARITY && w_rx_smp) r_rx_pbit <= r_rx_s2;
            if (r_rx_st == S_DATA && w_rx_adv)
                r_rx_bit <= (r_rx_bit == LAST_BIT) ? 4'd0 : r_rx_bit + 4'd1;
        end
    end

    // ---------------- RX FIFO and errors ----------------
    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_rx_wp, r_rx_rp;
    logic [CW-1:0]        r_rx_cnt;
    logic                 w_rx_full, w_rx_wr, w_rx_pop, w_perr, w_ferr, w_ovf;
    logic                 r_perr, r_ferr, r_ovf, r_rts;

    // A pop at full does not make room for a same-cycle push.
    assign w_rx_full = (r_rx_cnt == FULL);
    assign w_rx_pop  = Rx_Ready && (r_rx_cnt != '0);
    assign w_rx_wr   = w_rx_push && !w_rx_full;
    assign w_ovf     = w_rx_push && w_rx_full;
    assign w_perr    = w_rx_push && r_rx_par_en && (r_rx_pbit != ((^r_rx_sh) ^ r_rx_par_odd));
    assign w_ferr    = w_rx_push && !r_rx_s2;

    always_ff @(posedge SysClk) begin
        if (w_rx_wr) r_rx_mem[r_rx_wp] <= r_rx_sh;
    end

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0; r_rts <= 1'b0;
            r_perr <= 1'b0; r_ferr <= 1'b0; r_ovf <= 1'b0;
        end else begin
            if (w_rx_wr)  r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop) r_rx_rp <= r_rx_rp + AW'(1);
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_wr) - CW'(w_rx_pop);
            r_rts    <= (r_rx_cnt < RTS_LIM);
            // a same-cycle set outranks the clear
            r_perr   <= w_perr | (r_perr & ~Err_Clr);
            r_ferr   <= w_ferr | (r_ferr & ~Err_Clr);
            r_ovf    <= w_ovf  | (r_ovf  & ~Err_Clr);
        end
    end

    assign Rx_Data       = r_rx_mem[r_rx_rp];
    assign Rx_Valid      = (r_rx_cnt != '0);
    assign Rx_Count      = r_rx_cnt;
    assign RTS           = r_rts;
    assign Rx_Parity_Err = r_perr;
    assign Rx_Frame_Err  = r_ferr;
    assign Rx_Overflow   = r_ovf;
endmodule

// File: tb/tb_uart_cfg_core.sv
// Self-checking bench for uart_cfg_core: TX frame table, loopback, flow
// control, error flags, RX overflow, randomized RX frames and mid-frame reset.
module tb_uart_cfg_core;
    logic        SysClk = 1'b0, Rst = 1'b0;
    logic [15:0] Baud_Div;
    logic [1:0]  Parity_Mode;
    logic        Two_Stop, Loopback, Tx_Valid, Tx_Ready, Rx_Valid, Rx_Ready;
    logic [7:0]  Tx_Data, Rx_Data;
    logic        Rx, Tx, CTS, RTS, Tx_Busy, Err_Clr;
    logic [4:0]  Tx_Count, Rx_Count;
    logic        Rx_Parity_Err, Rx_Frame_Err, Rx_Overflow;

    uart_cfg_core #(.DATA_BITS(8), .FIFO_DEPTH(16), .RTS_MARGIN(2)) dut (
        .SysClk(SysClk), .Rst(Rst), .Baud_Div(Baud_Div), .Parity_Mode(Parity_Mode),
        .Two_Stop(Two_Stop), .Loopback(Loopback), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid),
        .Tx_Ready(Tx_Ready), .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid), .Rx_Ready(Rx_Ready),
        .Rx(Rx), .Tx(Tx), .CTS(CTS), .RTS(RTS), .Tx_Busy(Tx_Busy), .Tx_Count(Tx_Count),
        .Rx_Count(Rx_Count), .Err_Clr(Err_Clr), .Rx_Parity_Err(Rx_Parity_Err),
        .Rx_Frame_Err(Rx_Frame_Err), .Rx_Overflow(Rx_Overflow));

    always #5 SysClk = ~SysClk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(negedge SysClk);
    endtask

    function automatic int bcyc(input logic [15:0] div);
        return 16 * ((div == 16'd0) ? 1 : int'(div));
    endfunction

    // Expected line bits of one frame, first bit at [11], unused positions 0.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic [1:0] pm,
                                               input logic two, output int nb);
        logic [11:0] r;
        int k;
        r = '0; k = 1;
        for (int i = 0; i < 8; i++) begin r[11-k] = d[i]; k++; end
        if (pm == 2'b01 || pm == 2'b10) begin r[11-k] = (^d) ^ (pm == 2'b10); k++; end
        r[11-k] = 1'b1; k++;
        if (two) begin r[11-k] = 1'b1; k++; end
        nb = k;
        return r;
    endfunction

    task automatic wr(input logic [7:0] d);
        @(negedge SysClk); Tx_Data = d; Tx_Valid = 1'b1;
        @(negedge SysClk); Tx_Valid = 1'b0;
    endtask

    // Waits for a start bit on Tx, then samples nbits bit centres.
    task automatic cap_tx(input int nbits, input int bc, input bit flip,
                          output logic [11:0] got, output int lat, output int cyc);
        got = '0; lat = 0; cyc = 0;
        while (Tx !== 1'b0 && lat < 4000) begin @(negedge SysClk); lat++; end
        chk("tx_start_seen", Tx, 1'b0);
        if (Tx !== 1'b0) return;
        if (flip) begin Parity_Mode = Parity_Mode ^ 2'b11; Two_Stop = ~Two_Stop; end
        clk(bc / 2); cyc = bc / 2;
        got[11] = Tx;
        for (int i = 1; i < nbits; i++) begin
            clk(bc); cyc += bc;
            got[11-i] = Tx;
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic [1:0] pm, input bit bad_par,
                           input bit bad_stop, input int bc);
        @(negedge SysClk); Parity_Mode = pm;
        Rx = 1'b0; clk(bc);
        for (int i = 0; i < 8; i++) begin Rx = d[i]; clk(bc); end
        if (pm == 2'b01 || pm == 2'b10) begin
            Rx = (^d) ^ (pm == 2'b10) ^ bad_par; clk(bc);
        end
        Rx = ~bad_stop; clk(bc);
        Rx = 1'b1; clk(bc);
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        chk({nm, "_valid"}, Rx_Valid, 1'b1);
        chk({nm, "_data"}, Rx_Data, exp);
        Rx_Ready = 1'b1; clk(1); Rx_Ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  pm;
        logic        two;
        logic [15:0] div;
        int          nbits;
        logic [11:0] exp;
    } txv_t;
    txv_t tv[7];

    logic [11:0] got, ex;
    int          lat, cyc, nb, zeros, bc, cnt;
    logic [7:0]  d, q[$];
    logic [1:0]  pm;
    bit          bp, bs, m_perr, m_ferr;

    initial begin
        tv[0] = '{8'hA5, 2'b00, 1'b0, 16'd4, 10, 12'b0101_0010_1100};
        tv[1] = '{8'h03, 2'b01, 1'b0, 16'd4, 11, 12'b0110_0000_0010};
        tv[2] = '{8'h03, 2'b10, 1'b1, 16'd4, 12, 12'b0110_0000_0111};
        tv[3] = '{8'h80, 2'b00, 1'b1, 16'd2, 11, 12'b0000_0000_1110};
        tv[4] = '{8'hFE, 2'b10, 1'b0, 16'd2, 11, 12'b0011_1111_1010};
        tv[5] = '{8'h01, 2'b11, 1'b0, 16'd0, 10, 12'b0100_0000_0100};
        tv[6] = '{8'h01, 2'b11, 1'b0, 16'd1, 10, 12'b0100_0000_0100};

        Baud_Div = 16'd4; Parity_Mode = 2'b00; Two_Stop = 1'b0; Loopback = 1'b0;
        Tx_Data = '0; Tx_Valid = 1'b0; Rx_Ready = 1'b0; Rx = 1'b1; CTS = 1'b1; Err_Clr = 1'b0;

        // reset state
        clk(3);
        chk("rst_tx", Tx, 1'b1);
        chk("rst_rts", RTS, 1'b0);
        chk("rst_txrdy", Tx_Ready, 1'b1);
        chk("rst_rxvalid", Rx_Valid, 1'b0);
        chk("rst_counts", {Tx_Count, Rx_Count}, 10'd0);
        chk("rst_errs", {Rx_Parity_Err, Rx_Frame_Err, Rx_Overflow}, 3'd0);
        chk("rst_busy", Tx_Busy, 1'b0);
        Rst = 1'b1; clk(1);
        chk("rts_after_rst", RTS, 1'b1);
        clk(4);

        // TX frame table; config flipped mid-frame must not matter
        for (int r = 0; r < 7; r++) begin
            Baud_Div = tv[r].div; Parity_Mode = tv[r].pm; Two_Stop = tv[r].two;
            bc = bcyc(tv[r].div);
            wr(tv[r].d);
            cap_tx(tv[r].nbits, bc, 1'b1, got, lat, cyc);
            chk($sformatf("tx_frame%0d", r), got, tv[r].exp);
            chk($sformatf("tx_lat%0d", r), lat <= bc + 3, 1'b1);
            while (Tx_Busy && cyc < 4000) begin clk(1); cyc++; end
            chk($sformatf("tx_len%0d", r), cyc, tv[r].nbits * bc);
            clk(5);
        end
        Parity_Mode = 2'b00; Two_Stop = 1'b0;

        // loopback, even parity
        Baud_Div = 16'd2; Parity_Mode = 2'b01; Loopback = 1'b1; clk(4);
        wr(8'h00); wr(8'hFF); wr(8'h3C);
        zeros = 0; cnt = 0;
        while (Rx_Count != 5'd3 && cnt < 3000) begin
            clk(1); cnt++;
            if (Tx !== 1'b1) zeros++;
        end
        chk("lb_count", Rx_Count, 5'd3);
        chk("lb_tx_high", zeros, 0);
        pop_chk("lb0", 8'h00); pop_chk("lb1", 8'hFF); pop_chk("lb2", 8'h3C);
        chk("lb_errs", {Rx_Parity_Err, Rx_Frame_Err, Rx_Overflow}, 3'd0);
        while (Tx_Busy && cnt < 6000) begin clk(1); cnt++; end
        Loopback = 1'b0; Parity_Mode = 2'b00; clk(4);

        // CTS hold then three back-to-back frames
        Baud_Div = 16'd4; bc = 64; CTS = 1'b0; clk(4);
        wr(8'h11); wr(8'h22); wr(8'h33);
        zeros = 0;
        for (int i = 0; i < 300; i++) begin clk(1); if (Tx !== 1'b1) zeros++; end
        chk("cts_tx_high", zeros, 0);
        chk("cts_busy", Tx_Busy, 1'b1);
        chk("cts_count", Tx_Count, 5'd3);
        CTS = 1'b1;
        for (int f = 0; f < 3; f++) begin
            d = 8'h11 * 8'(f + 1);
            ex = frame_bits(d, 2'b00, 1'b0, nb);
            cap_tx(nb, bc, 1'b0, got, lat, cyc);
            chk($sformatf("b2b_frame%0d", f), got, ex);
            if (f > 0) chk($sformatf("b2b_gap%0d", f), lat <= bc / 2 + 4 + 2, 1'b1);
        end
        cnt = 0;
        while (Tx_Busy && cnt < 2000) begin clk(1); cnt++; end
        chk("b2b_done", {Tx_Busy, Tx_Count}, 6'd0);

        // parity error then framing error
        Baud_Div = 16'd2; bc = 32;
        send_rx(8'h55, 2'b10, 1'b1, 1'b0, bc);
        send_rx(8'hC3, 2'b00, 1'b0, 1'b1, bc);
        chk("err_count", Rx_Count, 5'd2);
        pop_chk("err0", 8'h55); pop_chk("err1", 8'hC3);
        chk("err_flags", {Rx_Parity_Err, Rx_Frame_Err, Rx_Overflow}, 3'b110);
        Err_Clr = 1'b1; clk(1); Err_Clr = 1'b0;
        chk("err_clr", {Rx_Parity_Err, Rx_Frame_Err}, 2'b00);

        // RX overflow and RTS threshold
        q.delete();
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 13 + 5);
            if (i < 16) q.push_back(d);
            send_rx(d, 2'b00, 1'b0, 1'b0, bc);
            cnt = (i + 1 > 16) ? 16 : i + 1;
            chk($sformatf("ovf_count%0d", i), Rx_Count, cnt);
            chk($sformatf("ovf_rts%0d", i), RTS, (16 - cnt) > 2);
            chk($sformatf("ovf_flag%0d", i), Rx_Overflow, i == 16);
        end
        for (int i = 0; i < 16; i++) pop_chk($sformatf("ovf_pop%0d", i), q.pop_front());
        chk("ovf_empty", Rx_Valid, 1'b0);
        Err_Clr = 1'b1; clk(1); Err_Clr = 1'b0;
        chk("ovf_clr", Rx_Overflow, 1'b0);

        // randomized RX frames against a frame-level model
        m_perr = 1'b0; m_ferr = 1'b0;
        for (int n = 0; n < 25; n++) begin
            Baud_Div = 16'($urandom_range(1, 3)); bc = bcyc(Baud_Div);
            d  = 8'($urandom);
            pm = 2'($urandom_range(0, 3));
            bp = ($urandom_range(0, 4) == 0);
            bs = ($urandom_range(0, 5) == 0);
            send_rx(d, pm, bp, bs, bc);
            m_perr |= bp && (pm == 2'b01 || pm == 2'b10);
            m_ferr |= bs;
            chk($sformatf("rnd_perr%0d", n), Rx_Parity_Err, m_perr);
            chk($sformatf("rnd_ferr%0d", n), Rx_Frame_Err, m_ferr);
            pop_chk($sformatf("rnd%0d", n), d);
            if ($urandom_range(0, 2) == 0) begin
                Err_Clr = 1'b1; clk(1); Err_Clr = 1'b0;
                m_perr = 1'b0; m_ferr = 1'b0;
            end
        end
        chk("rnd_ovf", Rx_Overflow, 1'b0);
        Parity_Mode = 2'b00;

        // fill TX FIFO with CTS low, then reset mid-frame
        Baud_Div = 16'd4; bc = 64; CTS = 1'b0; clk(4);
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("full_count", Tx_Count, 5'd16);
        chk("full_ready", Tx_Ready, 1'b0);
        wr(8'hEE);
        chk("full_nowrite", Tx_Count, 5'd16);
        CTS = 1'b1;
        cnt = 0;
        while (Tx !== 1'b0 && cnt < 1000) begin clk(1); cnt++; end
        clk(bc + bc / 2);
        chk("mid_count", Tx_Count, 5'd15);
        #2 Rst = 1'b0;
        #1 chk("rst_async_tx", Tx, 1'b1);
        chk("rst_flush", {Tx_Count, Tx_Busy}, 6'd0);
        clk(2); Rst = 1'b1;
        zeros = 0;
        for (int i = 0; i < 2 * bc; i++) begin clk(1); if (Tx !== 1'b1) zeros++; end
        chk("rst_no_partial", zeros, 0);
        chk("rst_ready", {Tx_Ready, Tx_Busy}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
